approx_add_pipe: RTL and testbench
==================================

// Module: approx_add_pipe
// PURPOSE
//  Parametrised, pipelined approximate adder/accumulator; next generation of the single-bit LUT cells.
//  Low k bits use an OR-based approximate cell; upper bits are exact. k is run-time selectable.
//  Valid/ready streaming I/O with an internal accumulator mode. Sits between operand fetch and the
//  approximate datapath writeback.
// PARAMETERS
//  WIDTH       16  operand/result width in bits (>=4)
//  MAX_APPROX   8  largest approximation level k (1..WIDTH-1)
//  KW          $clog2(MAX_APPROX+1)  width of cfg_k (localparam)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  cfg_we     in   1      load cfg_k into the level register this cycle
//  cfg_k      in   KW     requested approximation level
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts a beat (combinational)
//  in_op      in   2      00 ADD, 01 ACC, 10 CLR, 11 reserved (treated as ADD)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B (ignored for ACC/CLR)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  - Reset, any cycle: out_valid=0, out_sum=0, out_cout=0, acc=0, k=0, stage-1 valid=0.
//    In-flight beats are discarded. in_ready=1 the cycle after reset deasserts.
//  - Pipeline, 2 stages:
//      S1 registers op, a, b and the current k.
//      S2 computes the result and registers out_*.
//  - Handshake:
//      adv2 = ~out_valid | out_ready
//      adv1 = ~s1_valid | adv2
//      in_ready = adv1
//  - A beat is transferred when valid & ready. Latency is 2 cycles from accept to out_valid when unstalled.
//  - Throughput is 1 beat/cycle. Order is preserved; no beat is lost or duplicated under stall.
//  - out_* are held stable while out_valid & ~out_ready.
//  - Level register:
//      cfg_we loads min(cfg_k, MAX_APPROX).
//      Applies to beats accepted from the next cycle onward; beats already in flight keep their sampled k.
//      cfg_we and an accept in the same cycle: the beat uses the old k.
//  - Arithmetic on x, y with level k (no carry-in):
//      i < k : s[i] = x[i] | y[i]
//      carry into bit k = (k>0) ? x[k-1] & y[k-1] : 0
//      bits k..WIDTH-1 : exact ripple sum
//      out_cout = carry out of the MSB
//      k=0 gives the exact sum mod 2^WIDTH.
//  - ADD: x=a, y=b; acc unchanged.
//  - ACC: x=acc, y=a.
//      acc <= s when the beat moves into S2; out_sum = new acc.
//      acc wraps mod 2^WIDTH; the carry is reported in out_cout only.
//  - CLR: acc <= 0; out_sum=0, out_cout=0; a result beat is still produced.
//  - acc updates only on the S1->S2 transfer. Back-to-back ACC beats chain correctly without bubbles.
//  - Reserved op 11 behaves as ADD.
// STRUCTURE
//  - Package approx_pkg: OP_ADD/OP_ACC/OP_CLR localparam encodings and the op width constant.
//    Shared with the other approximate units.
//  - Sub-module approx_loa_adder: combinational WIDTH/MAX_APPROX adder.
//      Ports: x, y, k -> s, cout.
//      Per-bit mask (i<k) selects the OR cell or the exact full adder. Instantiated once, in S2.
//  - Top level holds the S1 regs, S2/out regs, acc, k register and handshake logic. No FSM beyond
//    the valid bits.
// TESTING (WIDTH=16, MAX_APPROX=8, out_ready=1 unless stated)
//  1. k=0, ADD a=0x00FF b=0x0001 -> 2 cycles later out_sum=0x0100, out_cout=0.
//  2. k=4, ADD a=0x0008 b=0x0008 -> out_sum=0x0018 (exact would be 0x0010).
//     Then a=0x000F b=0x0001 -> 0x000F.
//  3. cfg_k=12 -> level clamps to 8.
//     ADD a=0x00F0 b=0x0010 -> low byte OR=0xF0, carry=0 -> 0x00F0.
//  4. k=0: CLR, ACC a=0xFFFF, ACC a=0x0002, issued back-to-back ->
//     outputs 0x0000/c0, 0xFFFF/c0, 0x0001/c1; acc=0x0001.
//  5. out_ready=0 for 5 cycles while streaming 4 ADD beats ->
//     in_ready drops after 2 accepts, out_* stable; on release all 4 results emerge in order, no duplicates.
//  6. rst pulsed for 1 cycle with both stages full and acc=0x1234 ->
//     next cycle out_valid=0, out_sum=0, acc=0, k=0; first new ADD a=1 b=1 gives 0x0002.

Source files
------------

// File: rtl/approx_pkg.sv
// Shared encodings for the approximate arithmetic units.
package approx_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_ACC = 2'b01;
  localparam logic [OP_W-1:0] OP_CLR = 2'b10;
  // 2'b11 is reserved and decodes as OP_ADD wherever it is seen.

endpackage

// File: rtl/approx_loa_adder.sv
// Lower-part-OR approximate adder. Bits below k use an OR cell; bits k and up are an exact
// ripple adder whose carry-in is the AND of the top approximate bit pair.
module approx_loa_adder #(
  parameter int WIDTH      = 16,
  parameter int MAX_APPROX = 8,
  localparam int KW        = $clog2(MAX_APPROX + 1)
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] mask;
  logic [WIDTH:0]   c;

  // Per-bit selector: 1 marks an approximate (OR) cell.
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (i < int'(k));
    end
  end

  // Bit-serial sum. In the OR region the carry only matters at bit k-1, where it feeds the
  // exact part; lower carries are overwritten before they are consumed.
  always_comb begin
    s    = '0;
    c    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) begin
        s[i]   = x[i] | y[i];
        c[i+1] = x[i] & y[i];
      end else begin
        s[i]   = x[i] ^ y[i] ^ c[i];
        c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
    end
    cout = c[WIDTH];
  end

endmodule

// File: rtl/approx_add_pipe.sv
// Two-stage valid/ready approximate adder/accumulator. S1 captures op, operands and the level
// in force at accept time; S2 computes and registers the result and owns the accumulator.
module approx_add_pipe
  import approx_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_APPROX = 8,
  localparam int KW        = $clog2(MAX_APPROX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [KW-1:0]    cfg_k,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam logic [KW-1:0] KMAX = KW'(MAX_APPROX);

  logic [KW-1:0]    k_q;
  logic             s1_valid;
  logic [OP_W-1:0]  s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [KW-1:0]    s1_k;
  logic [WIDTH-1:0] acc_q;

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  // Pipeline advance: a stage moves when it is empty or the stage after it moves.
  always_comb begin
    adv2     = ~out_valid | out_ready;
    adv1     = ~s1_valid | adv2;
    in_ready = adv1;
  end

  // Level register; oversize requests clamp to the largest supported level.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
    end else if (cfg_we) begin
      k_q <= (cfg_k > KMAX) ? KMAX : cfg_k;
    end
  end

  // Stage 1: capture the accepted beat together with the level sampled at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_k     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= in_op;
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_k  <= k_q;
      end
    end
  end

  // Operand select: ACC adds operand A onto the accumulator, everything else adds A and B.
  always_comb begin
    add_x = s1_a;
    add_y = s1_b;
    if (s1_op == OP_ACC) begin
      add_x = acc_q;
      add_y = s1_a;
    end
  end

  approx_loa_adder #(
    .WIDTH      (WIDTH),
    .MAX_APPROX (MAX_APPROX)
  ) u_adder (
    .x    (add_x),
    .y    (add_y),
    .k    (s1_k),
    .s    (add_s),
    .cout (add_cout)
  );

  // CLR forces a zero result beat.
  always_comb begin
    res_sum  = add_s;
    res_cout = add_cout;
    if (s1_op == OP_CLR) begin
      res_sum  = '0;
      res_cout = 1'b0;
    end
  end

  // Stage 2: result registers and accumulator, updated only on the S1->S2 transfer so that
  // back-to-back ACC beats see the freshly written accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      acc_q     <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum  <= res_sum;
        out_cout <= res_cout;
        if (s1_op == OP_ACC) begin
          acc_q <= add_s;
        end else if (s1_op == OP_CLR) begin
          acc_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Scoreboard bench for approx_add_pipe: expected results are modelled when a beat is accepted
// and compared in order whenever a result beat is presented.
module tb_approx_add_pipe;

  localparam int WIDTH      = 16;
  localparam int MAX_APPROX = 8;
  localparam int KW         = $clog2(MAX_APPROX + 1);

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] ACC = 2'b01;
  localparam logic [1:0] CLR = 2'b10;
  localparam logic [1:0] RSV = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [KW-1:0]    cfg_k;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  approx_add_pipe #(
    .WIDTH      (WIDTH),
    .MAX_APPROX (MAX_APPROX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_k     (cfg_k),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } res_t;

  res_t             sb[$];
  int               n_vec = 0;
  int               n_err = 0;
  int               n_acc = 0;
  int               mdl_k = 0;
  logic [WIDTH-1:0] mdl_acc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Arithmetic reference: OR the low k bits, add the shifted upper parts plus the AND carry.
  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input int k);
    int unsigned xi, yi, mask, low, c, hi, full;
    res_t r;
    xi   = 32'(x);
    yi   = 32'(y);
    mask = (32'd1 << k) - 1;
    low  = (xi | yi) & mask;
    c    = (k > 0) ? (((xi >> (k - 1)) & (yi >> (k - 1))) & 32'd1) : 32'd0;
    hi   = (xi >> k) + (yi >> k) + c;
    full = (hi << k) | low;
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    return r;
  endfunction

  // Monitor: sampled mid-cycle, so every signal shows what the next rising edge will do.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        mdl_acc = '0;
        mdl_k   = 0;
      end else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
          end else begin
            check("out_sum", 32'(out_sum), 32'(sb[0].sum));
            check("out_cout", 32'(out_cout), 32'(sb[0].cout));
            if (out_ready) void'(sb.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          n_acc++;
          if (in_op == ACC) begin
            r       = model(mdl_acc, in_a, mdl_k);
            mdl_acc = r.sum;
          end else if (in_op == CLR) begin
            r       = '0;
            mdl_acc = '0;
          end else begin
            r = model(in_a, in_b, mdl_k);
          end
          sb.push_back(r);
        end
        if (cfg_we) mdl_k = (int'(cfg_k) > MAX_APPROX) ? MAX_APPROX : int'(cfg_k);
      end
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic set_k(input int k);
    cfg_we = 1'b1;
    cfg_k  = KW'(k);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc0;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_k     = '0;
    in_valid  = 1'b0;
    in_op     = ADD;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Exact add with k=0 and two-cycle latency.
    in_valid = 1'b1;
    in_op    = ADD;
    in_a     = 16'h00FF;
    in_b     = 16'h0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat2_out_valid", 32'(out_valid), 32'd1);
    check("t1_sum", 32'(out_sum), 32'h0100);
    check("t1_cout", 32'(out_cout), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // k=4 approximate adds; then cfg_we coinciding with an accept keeps the old level.
    set_k(4);
    send(ADD, 16'h0008, 16'h0008);
    send(ADD, 16'h000F, 16'h0001);
    cfg_we = 1'b1;
    cfg_k  = '0;
    send(ADD, 16'h0008, 16'h0008);
    cfg_we = 1'b0;
    send(ADD, 16'h0008, 16'h0008);
    drain();

    // Oversize level clamps to MAX_APPROX; reserved op acts as ADD.
    set_k(12);
    send(ADD, 16'h00F0, 16'h0010);
    send(RSV, 16'h01C3, 16'h0381);
    drain();

    // Back-to-back accumulate chain with wrap.
    set_k(0);
    send(CLR, 16'h5555, 16'hAAAA);
    send(ACC, 16'hFFFF, 16'h1234);
    send(ACC, 16'h0002, 16'h0000);
    send(ADD, 16'h0001, 16'h0001);
    send(ACC, 16'h0000, 16'h0000);
    drain();

    // Output stall while streaming four beats.
    out_ready = 1'b0;
    acc0      = n_acc;
    fork
      begin
        send(ADD, 16'h1111, 16'h0001);
        send(ADD, 16'h2222, 16'h0002);
        send(ADD, 16'h3333, 16'h0003);
        send(ADD, 16'h4444, 16'h0004);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_accepts", 32'(n_acc - acc0), 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random back-pressure and level changes.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if (i % 9 == 0) set_k(int'($urandom_range(0, 15)));
          send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        end
      end
      begin
        repeat (90) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with both stages full and a non-zero accumulator and level.
    send(CLR, 16'h0000, 16'h0000);
    send(ACC, 16'h1234, 16'h0000);
    drain();
    set_k(3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = ADD;
    in_a      = 16'h0005;
    in_b      = 16'h0005;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_out_sum", 32'(out_sum), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(ADD, 16'h0001, 16'h0001);
    send(ACC, 16'h0000, 16'h0000);
    send(ADD, 16'h0008, 16'h0008);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
